// File: rtl/cam_frame_capture.sv
// cam_frame_capture: pairs OV7670 RGB565 camera bytes into 16-bit pixels and
// emits linear frame-buffer write strobes for one vsync-delimited frame.
// Optional feature: define CAM_CAPTURE_CONTINUOUS_EN to re-arm after every frame.
module cam_frame_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_req,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        p_data,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              err
);
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int RW = $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0]     H_C = CW'(H_ACTIVE);
    localparam logic [RW-1:0]     V_C = RW'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] H_A = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DONE} state_t;
    state_t state_q, state_d;

    logic              vs_q, hr_q, vs2_q, hr2_q;
    logic [7:0]        d_q, hi_q, hi_d;
    logic              phase_q, phase_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
    logic              wr_en_q, wr_en_d, err_q, err_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;

    // Edge detectors compare the registered pins against a second stage.
    logic vs_fall, vs_rise, hr_fall, line_end, phase_n;
    logic [CW-1:0]     col_n;
    logic [RW-1:0]     row_n;
    logic [ADDR_W-1:0] base_n;

    assign vs_fall = vs2_q & ~vs_q;
    assign vs_rise = vs_q & ~vs2_q;
    assign hr_fall = hr2_q & ~hr_q;

    // Camera pins are registered once, then once more for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q  <= 1'b0;
            hr_q  <= 1'b0;
            d_q   <= 8'h00;
            vs2_q <= 1'b0;
            hr2_q <= 1'b0;
        end else begin
            vs_q  <= vsync;
            hr_q  <= href;
            d_q   <= p_data;
            vs2_q <= vs_q;
            hr2_q <= hr_q;
        end
    end

    // Capture sequencing: wait for a full frame start, capture, then report.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture_req) state_d = ARM;
            ARM:     if (vs_fall) state_d = ACTIVE;
            ACTIVE:  if (vs_rise) state_d = DONE;
            DONE: begin
`ifdef CAM_CAPTURE_CONTINUOUS_EN
                state_d = ARM;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte pairing, running address counters and geometry error detection.
    always_comb begin
        hi_d      = hi_q;
        phase_d   = phase_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        base_d    = base_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        col_n     = col_q;
        row_n     = row_q;
        base_n    = base_q;
        phase_n   = phase_q;
        line_end  = 1'b0;
        if (state_q == IDLE && capture_req) begin
            err_d = 1'b0;
        end
        if (state_q == ARM && vs_fall) begin
            phase_d = 1'b0;
            col_d   = '0;
            row_d   = '0;
            addr_d  = '0;
            base_d  = '0;
`ifdef CAM_CAPTURE_CONTINUOUS_EN
            err_d   = 1'b0;
`endif
        end
        if (state_q == ACTIVE) begin
            if (hr_q) begin
                phase_n = ~phase_q;
                if (!phase_q) begin
                    hi_d = d_q;
                end else begin
                    wr_data_d = {hi_q, d_q};
                    if (col_q < H_C) begin
                        // Pixels beyond the last row still advance col, but are never written.
                        if (row_q < V_C) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                        end
                        col_n  = col_q + CW'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            phase_d  = phase_n;
            col_d    = col_n;
            // A vsync rise while href is still high terminates the line in progress.
            line_end = hr_fall | (vs_rise & hr_q);
            if (line_end) begin
                if (col_n != H_C || phase_n) err_d = 1'b1;
                if (row_q < V_C) begin
                    row_n  = row_q + RW'(1);
                    base_n = base_q + H_A;
                end
                row_d   = row_n;
                base_d  = base_n;
                addr_d  = base_n;
                col_d   = '0;
                phase_d = 1'b0;
            end
            if (vs_rise && row_n != V_C) err_d = 1'b1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= 8'h00;
            phase_q   <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            base_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            phase_q   <= phase_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            base_q    <= base_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign err        = err_q;
endmodule

// File: tb/tb_cam_frame_capture.sv
// Testbench for cam_frame_capture: frames are described as line byte counts;
// a frame-level model derives the expected writes and error flag.
module tb_cam_frame_capture;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst, capture_req, vsync, href;
    logic [7:0]    p_data;
    logic          busy, wr_en, frame_done, err;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;

    cam_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .capture_req(capture_req), .vsync(vsync),
        .href(href), .p_data(p_data), .busy(busy), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    int            vectors = 0;
    int            miscompares = 0;
    int            done_cnt = 0;
    int            frame_wr = 0;
    logic [AW-1:0] first_addr;
    logic [15:0]   first_data;
    bit            expect_done = 1'b0;
    bit            exp_err = 1'b0;
    int            line_len[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Compare process: every write and every frame_done against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: addr=%0d data=%h, no write expected", wr_addr, wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.a !== wr_addr || mon_e.d !== wr_data) begin
                        miscompares++;
                        $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                                 wr_addr, wr_data, mon_e.a, mon_e.d);
                    end
                end
                if (frame_wr == 0) begin
                    first_addr = wr_addr;
                    first_data = wr_data;
                end
                frame_wr++;
            end
            if (frame_done) begin
                vectors++;
                done_cnt++;
                if (!expect_done) begin
                    miscompares++;
                    $display("FAIL unexpected_frame_done: frame_done=1 expected 0");
                end else if (err !== exp_err || exp_q.size() != 0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL frame_end: err=%b busy=%b pending=%0d expected err=%b busy=1 pending=0",
                             err, busy, exp_q.size(), exp_err);
                end
                expect_done = 1'b0;
            end
        end
    end

    // Drives one frame; when live, the model queues the writes it must cause.
    task automatic send_frame(input int nl, input bit capt, input bit req_start, input bit req_mid,
                              input bit href_at_vs, input bit seq, input int rst_line);
        int         idx = 0;
        int         d0;
        int         n;
        logic [7:0] hi_b, b8;
        bit         live;
        live = capt;
        d0 = done_cnt;
        hi_b = 8'h00;
        frame_wr = 0;
        if (capt) begin
            exp_err = (nl < V);
            for (int l = 0; l < nl; l++) if (line_len[l] != 2 * H) exp_err = 1'b1;
            expect_done = 1'b1;
        end
        vsync = 1'b1;
        href = 1'b0;
        for (int i = 0; i < 3; i++) begin
            capture_req = req_start && (i == 1);
            step();
        end
        capture_req = 1'b0;
        if (req_start) chk("busy_after_req", 32'(busy), 32'd1);
        vsync = 1'b0;
        repeat (3) step();
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < line_len[l]; b++) begin
                b8 = seq ? 8'(8'h12 + 8'h22 * idx) : 8'($urandom);
                idx++;
                href = 1'b1;
                p_data = b8;
                capture_req = req_mid && (l == 0) && (b == 1);
                if (href_at_vs && l == nl - 1 && b == line_len[l] - 1) vsync = 1'b1;
                if (b % 2 == 0) hi_b = b8;
                else if (live && b / 2 < H && l < V)
                    exp_q.push_back('{a: AW'(l * H + b / 2), d: {hi_b, b8}});
                step();
                if (rst_line == l && b == 2) begin
                    #3 rst = 1'b1;
                    #1;
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_wr_en", 32'(wr_en), 32'd0);
                    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
                    chk("rst_wr_data", 32'(wr_data), 32'd0);
                    chk("rst_frame_done", 32'(frame_done), 32'd0);
                    chk("rst_err", 32'(err), 32'd0);
                    exp_q.delete();
                    expect_done = 1'b0;
                    live = 1'b0;
                    @(posedge clk);
                    #1 rst = 1'b0;
                end
            end
            capture_req = 1'b0;
            if (!(href_at_vs && l == nl - 1)) begin
                href = 1'b0;
                repeat (3) step();
            end
        end
        href = 1'b0;
        vsync = 1'b1;
        capture_req = 1'b0;
        if (live) begin
            n = 0;
            while (done_cnt == d0 && n < 20) begin
                step();
                n++;
            end
            if (done_cnt == d0) begin
                miscompares++;
                $display("FAIL frame_done_timeout: no frame_done within 20 cycles, expected one");
            end else begin
                chk("busy_after_done", 32'(busy), 32'd0);
            end
        end else begin
            repeat (6) step();
            chk("no_frame_done", 32'(done_cnt), 32'(d0));
        end
    endtask

    initial begin
        int nl;
        rst = 1'b1;
        capture_req = 1'b0;
        vsync = 1'b0;
        href = 1'b0;
        p_data = 8'h00;
        repeat (2) step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        chk("reset_wr_data", 32'(wr_data), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        step();

        // Clean frame with a known byte ramp.
        line_len[0] = 8; line_len[1] = 8;
        send_frame(2, 1, 1, 0, 0, 1, -1);
        chk("clean_writes", 32'(frame_wr), 32'd8);
        chk("clean_first_addr", 32'(first_addr), 32'd0);
        chk("clean_first_data", 32'(first_data), 32'h1234);
        chk("clean_err", 32'(err), 32'd0);

        // Request in the middle of a frame: nothing until the next full frame.
        send_frame(2, 0, 0, 1, 0, 0, -1);
        chk("midreq_writes", 32'(frame_wr), 32'd0);
        send_frame(2, 1, 0, 0, 0, 0, -1);
        chk("midreq_next_writes", 32'(frame_wr), 32'd8);

        // Long first line.
        line_len[0] = 10; line_len[1] = 8;
        send_frame(2, 1, 1, 0, 0, 0, -1);
        chk("long_err", 32'(err), 32'd1);
        chk("long_writes", 32'(frame_wr), 32'd8);

        // Single line with an odd byte count.
        line_len[0] = 7;
        send_frame(1, 1, 1, 0, 0, 0, -1);
        chk("odd_err", 32'(err), 32'd1);
        chk("odd_writes", 32'(frame_wr), 32'd3);

        // vsync rises while href is still high on the last byte.
        line_len[0] = 8; line_len[1] = 8;
        send_frame(2, 1, 1, 0, 1, 0, -1);
        chk("hav_writes", 32'(frame_wr), 32'd8);
        chk("hav_err", 32'(err), 32'd0);

        // Reset in the middle of line 1, then a clean recovery frame.
        send_frame(2, 1, 1, 0, 0, 0, 1);
        send_frame(2, 1, 1, 0, 0, 0, -1);
        chk("recover_writes", 32'(frame_wr), 32'd8);

        // Randomized frame geometry and content.
        for (int f = 0; f < 40; f++) begin
            nl = ($urandom_range(0, 4) == 0) ? ($urandom_range(0, 1) ? 1 : 3) : 2;
            for (int l = 0; l < 8; l++)
                line_len[l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 11)) : 8;
            if ($urandom_range(0, 7) == 0) begin
                send_frame(nl, 0, 0, 1, 0, 0, -1);
                send_frame(nl, 1, 0, 0, $urandom_range(0, 3) == 0, 0, -1);
            end else begin
                send_frame(nl, 1, 1, 0, $urandom_range(0, 3) == 0, 0, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
